// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by uart_rx, uart_tx and the receive-side FIFO.
package uart_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned BAUD         = 9600;
  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam int unsigned DROP_CNT_W   = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream interface: uart_rx write strobe in, valid/ready consumer handshake out.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] pi_data;
  logic              pi_flag;
  logic [DATA_W-1:0] po_data;
  logic              po_valid;
  logic              po_ready;

  // master drives the bytes in and accepts them out; slave is the FIFO itself
  modport master (
    output pi_data,
    output pi_flag,
    input  po_data,
    input  po_valid,
    output po_ready
  );

  modport slave (
    input  pi_data,
    input  pi_flag,
    output po_data,
    output po_valid,
    input  po_ready
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx, with sticky overflow and a
// saturating drop counter so that back-pressure never loses bytes silently.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  uart_rx_fifo_if.slave         bus,
  output logic [ADDR_W:0]       fill_cnt,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       fill_cnt_q, fill_cnt_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              push;
  logic              pop;
  logic              drop;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  // Flags come only from the count register, keeping pi_flag/po_ready off their paths.
  assign full  = (fill_cnt_q == (ADDR_W+1)'(DEPTH));
  assign empty = (fill_cnt_q == '0);

  always_comb begin
    pop  = !empty && bus.po_ready;
    push = bus.pi_flag && (!full || pop);
    drop = bus.pi_flag && full && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   fill_cnt_d = fill_cnt_q + (ADDR_W+1)'(1);
      2'b01:   fill_cnt_d = fill_cnt_q - (ADDR_W+1)'(1);
      default: fill_cnt_d = fill_cnt_q;
    endcase

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = ovf_clr ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mem_we = push && !sys_rst;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (sys_clk),
    .we      (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.pi_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.po_valid = !empty;
  assign bus.po_data  = empty ? '0 : rd_data;

  assign fill_cnt = fill_cnt_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: latency, full/overflow boundaries, wrap order,
// drop counter saturation with clear collision, and mid-operation reset.
module tb_uart_rx_fifo;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [4:0] fill_cnt;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo_if #(.DATA_W(8)) fifo_if ();

  uart_rx_fifo #(
    .DEPTH  (16),
    .ADDR_W (4),
    .DATA_W (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (fifo_if),
    .fill_cnt (fill_cnt),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_if.pi_flag = 1'b1;
    fifo_if.pi_data = b;
    tick();
    fifo_if.pi_flag = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  int  sent;
  int  rcvd;
  int  cyc;
  bit  do_push;
  bit  rdy;

  initial begin
    sys_rst          = 1'b1;
    ovf_clr          = 1'b0;
    fifo_if.pi_flag  = 1'b0;
    fifo_if.pi_data  = '0;
    fifo_if.po_ready = 1'b0;
    repeat (2) tick();
    sys_rst = 1'b0;

    check("rst_fill", fill_cnt, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", fifo_if.po_valid, 0);
    check("rst_data", fifo_if.po_data, 8'h00);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);

    // 1: UART-paced bytes, consumer always ready
    fifo_if.po_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fifo_if.pi_flag = 1'b1;
      fifo_if.pi_data = 8'(i);
      check("t1_no_bypass", fifo_if.po_valid, 0);
      tick();
      fifo_if.pi_flag = 1'b0;
      check("t1_valid", fifo_if.po_valid, 1);
      check("t1_data", fifo_if.po_data, 32'(i));
      tick();
      check("t1_empty", empty, 1);
      check("t1_fill", fill_cnt, 0);
      repeat (5206) tick();
    end

    // 2: fill to full, overflow one byte, drain
    fifo_if.po_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
    check("t2_full", full, 1);
    check("t2_fill", fill_cnt, 16);
    push_byte(8'hFF);
    check("t2_ovf", overflow, 1);
    check("t2_drop", drop_cnt, 1);
    check("t2_fill_hold", fill_cnt, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t2_clr_ovf", overflow, 0);
    check("t2_clr_drop", drop_cnt, 0);
    fifo_if.po_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", fifo_if.po_data, 32'(8'hA0 + 8'(i)));
      tick();
    end
    fifo_if.po_ready = 1'b0;
    check("t2_empty", empty, 1);

    // 3: push into full FIFO with simultaneous pop
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    check("t3_full", full, 1);
    fifo_if.pi_flag  = 1'b1;
    fifo_if.pi_data  = 8'h55;
    fifo_if.po_ready = 1'b1;
    check("t3_head", fifo_if.po_data, 8'h10);
    tick();
    fifo_if.pi_flag = 1'b0;
    check("t3_fill", fill_cnt, 16);
    check("t3_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      check("t3_drain", fifo_if.po_data, 32'(8'h10 + 8'(i)));
      tick();
    end
    check("t3_last", fifo_if.po_data, 8'h55);
    tick();
    fifo_if.po_ready = 1'b0;
    check("t3_empty", empty, 1);

    // 4: 40 bytes with random back-pressure, pointers wrap twice
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 40 && cyc < 2000) begin
      do_push = (sent < 40) && (exp_q.size() < 16);
      rdy     = 1'($urandom_range(0, 1));
      fifo_if.pi_flag  = do_push;
      fifo_if.pi_data  = 8'(sent);
      fifo_if.po_ready = rdy;
      check("t4_valid", fifo_if.po_valid, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("t4_data", fifo_if.po_data, 32'(exp_q[0]));
        if (rdy) begin
          void'(exp_q.pop_front());
          rcvd++;
        end
      end
      if (do_push) begin
        exp_q.push_back(8'(sent));
        sent++;
      end
      tick();
      check("t4_fill", fill_cnt, 32'(exp_q.size()));
      cyc++;
    end
    fifo_if.pi_flag  = 1'b0;
    fifo_if.po_ready = 1'b0;
    check("t4_rcvd_timeout", rcvd, 40);
    check("t4_drop", drop_cnt, 0);
    check("t4_ovf", overflow, 0);

    // 5: saturate drop counter, then clear colliding with a drop, then clear alone
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    fifo_if.pi_flag = 1'b1;
    for (int i = 0; i < 300; i++) begin
      fifo_if.pi_data = 8'(i);
      tick();
    end
    fifo_if.pi_flag = 1'b0;
    check("t5_sat", drop_cnt, 255);
    check("t5_ovf", overflow, 1);
    check("t5_fill", fill_cnt, 16);
    fifo_if.pi_flag = 1'b1;
    ovf_clr         = 1'b1;
    tick();
    fifo_if.pi_flag = 1'b0;
    check("t5_clr_drop_ovf", overflow, 1);
    check("t5_clr_drop_cnt", drop_cnt, 1);
    tick();
    ovf_clr = 1'b0;
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_cnt", drop_cnt, 0);
    check("t5_head", fifo_if.po_data, 8'h00);

    // 6: reset during a push
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    check("t6_fill5", fill_cnt, 5);
    fifo_if.pi_flag = 1'b1;
    fifo_if.pi_data = 8'h99;
    sys_rst         = 1'b1;
    tick();
    sys_rst         = 1'b0;
    fifo_if.pi_flag = 1'b0;
    check("t6_fill", fill_cnt, 0);
    check("t6_empty", empty, 1);
    check("t6_valid", fifo_if.po_valid, 0);
    check("t6_data", fifo_if.po_data, 8'h00);
    push_byte(8'h3C);
    check("t6_after", fifo_if.po_data, 8'h3C);
    check("t6_after_fill", fill_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
